uart_loader: RTL and testbench

Boot loader stage directly downstream of the UART receiver. It consumes the receiver's toggle-style byte strobe and byte value, parses a framed image (length header, payload words, checksum), and writes little-endian 32-bit words into instruction memory through a valid/ready write port. It holds the CPU in reset until a complete, checksum-verified image has been written.

---
 rtl/uart_loader_pkg.sv | 23 ++
 rtl/uart_loader_if.sv | 23 ++
 rtl/uart_loader_toggle_event.sv | 27 ++
 rtl/uart_loader.sv | 165 ++++++++++++++++
 tb/tb_uart_loader.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_loader_pkg.sv
// Shared definitions for the UART boot loader: FSM states, frame constants
// and a little-endian byte shift helper.
package uart_loader_pkg;

    typedef enum logic [2:0] {
        ST_LEN   = 3'd0,
        ST_DATA  = 3'd1,
        ST_CSUM  = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } state_e;

    // Bytes in the word-count header and bytes per payload word
    localparam int unsigned HDR_BYTES  = 4;
    localparam int unsigned WORD_BYTES = 4;

    // Bytes arrive LSB first: each new byte enters at the top and the
    // accumulator shifts down, so after four bytes the first one is in [7:0].
    function automatic logic [31:0] shift_in(input logic [31:0] acc, input logic [7:0] b);
        return {b, acc[31:8]};
    endfunction

endpackage

// File: rtl/uart_loader_if.sv
// Instruction-memory write port: valid/ready handshake with word address and data.
interface uart_loader_if #(
    parameter int ADDR_WIDTH = 12
);
    logic                  mem_wvalid;
    logic                  mem_wready;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [31:0]           mem_wdata;

    modport master (
        output mem_wvalid,
        output mem_waddr,
        output mem_wdata,
        input  mem_wready
    );

    modport slave (
        input  mem_wvalid,
        input  mem_waddr,
        input  mem_wdata,
        output mem_wready
    );
endinterface

// File: rtl/uart_loader_toggle_event.sv
// Converts the receiver's toggle-style strobe into a one-cycle byte-event pulse.
// The first cycle after reset only primes the registered copy, because the
// receiver's update line has no defined reset value.
module toggle_event (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_update,
    output logic byte_ev
);

    logic primed_q;
    logic copy_q;

    // Priming flag and registered copy of the strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            primed_q <= 1'b0;
            copy_q   <= 1'b0;
        end else begin
            primed_q <= 1'b1;
            copy_q   <= rx_update;
        end
    end

    assign byte_ev = primed_q && (rx_update != copy_q);

endmodule

// File: rtl/uart_loader.sv
// Boot loader: parses a framed image from the UART receiver (word count,
// little-endian payload words, XOR checksum), writes words to instruction
// memory and releases the CPU from reset once the image is verified.
module uart_loader
    import uart_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int BASE_ADDR  = 0,
    parameter int MAX_WORDS  = 2**ADDR_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_update,
    input  logic [7:0]        rx_byte,
    uart_loader_if.master     mem,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam logic [31:0] MAX_N     = 32'(MAX_WORDS);
    localparam logic [1:0]  LAST_HDR  = 2'(HDR_BYTES - 1);
    localparam logic [1:0]  LAST_WORD = 2'(WORD_BYTES - 1);

    state_e                state_q;
    logic [1:0]            byte_cnt_q;
    logic [31:0]           len_q;
    logic [31:0]           asm_q;
    logic [7:0]            csum_q;
    logic                  csum_got_q;
    logic [7:0]            csum_rx_q;
    logic [ADDR_WIDTH:0]   word_idx_q;
    logic                  wvalid_q;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [31:0]           wdata_q;

    logic                  byte_ev;
    logic [31:0]           len_next;
    logic [31:0]           word_next;
    logic [ADDR_WIDTH:0]   idx_inc;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic                  last_word;
    logic                  wr_fire;
    logic                  wr_clear;
    logic                  csum_have;
    logic [7:0]            csum_rx;

    toggle_event u_toggle_event (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_update (rx_update),
        .byte_ev   (byte_ev)
    );

    // Datapath helpers shared by the state machine
    always_comb begin
        len_next  = shift_in(len_q, rx_byte);
        word_next = shift_in(asm_q, rx_byte);
        idx_inc   = word_idx_q + 1'b1;
        addr_next = ADDR_WIDTH'(BASE_ADDR) + word_idx_q[ADDR_WIDTH-1:0];
        last_word = (32'(idx_inc) == len_q);
        wr_fire   = wvalid_q && mem.mem_wready;
        wr_clear  = !wvalid_q || mem.mem_wready;
        // The checksum byte may arrive in the same cycle the decision is made
        csum_have = csum_got_q || byte_ev;
        csum_rx   = csum_got_q ? csum_rx_q : rx_byte;
    end

    // Frame parser, checksum accumulation and write-port ownership
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_LEN;
            byte_cnt_q <= '0;
            len_q      <= '0;
            asm_q      <= '0;
            csum_q     <= '0;
            csum_got_q <= 1'b0;
            csum_rx_q  <= '0;
            word_idx_q <= '0;
            wvalid_q   <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
        end else begin
            // A completed handshake retires the write; a new word below may re-arm it
            if (wr_fire) begin
                wvalid_q <= 1'b0;
            end

            case (state_q)
                ST_LEN: begin
                    if (byte_ev) begin
                        len_q      <= len_next;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == LAST_HDR) begin
                            if (len_next == '0) begin
                                state_q <= ST_CSUM;
                            end else if (len_next > MAX_N) begin
                                state_q <= ST_ERROR;
                            end else begin
                                state_q <= ST_DATA;
                            end
                        end
                    end
                end

                ST_DATA: begin
                    if (byte_ev) begin
                        asm_q      <= word_next;
                        csum_q     <= csum_q ^ rx_byte;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == LAST_WORD) begin
                            if (wvalid_q && !mem.mem_wready) begin
                                // Previous word still pending: overrun
                                state_q  <= ST_ERROR;
                                wvalid_q <= 1'b0;
                            end else begin
                                wvalid_q   <= 1'b1;
                                wdata_q    <= word_next;
                                waddr_q    <= addr_next;
                                word_idx_q <= idx_inc;
                                if (last_word) begin
                                    state_q <= ST_CSUM;
                                end
                            end
                        end
                    end
                end

                ST_CSUM: begin
                    if (byte_ev && !csum_got_q) begin
                        csum_got_q <= 1'b1;
                        csum_rx_q  <= rx_byte;
                    end
                    if (csum_have && wr_clear) begin
                        state_q <= (csum_rx == csum_q) ? ST_DONE : ST_ERROR;
                    end
                end

                ST_DONE: begin
                end

                ST_ERROR: begin
                    wvalid_q <= 1'b0;
                end

                default: begin
                    state_q  <= ST_ERROR;
                    wvalid_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem.mem_wvalid = wvalid_q;
    assign mem.mem_waddr  = waddr_q;
    assign mem.mem_wdata  = wdata_q;

    assign done      = (state_q == ST_DONE);
    assign error     = (state_q == ST_ERROR);
    assign cpu_rst_n = (state_q == ST_DONE);
    assign busy      = (state_q == ST_DATA) || (state_q == ST_CSUM) ||
                       ((state_q == ST_LEN) && (byte_cnt_q != '0));

endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader: frames are sent byte by byte over the
// toggle strobe, memory writes are logged, and outputs are compared with
// hand-computed values.
module tb_uart_loader;

    localparam int ADDR_WIDTH = 12;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_update = 1'b0;
    logic [7:0] rx_byte = '0;
    logic       cpu_rst_n;
    logic       busy;
    logic       done;
    logic       error;

    int n_checks = 0;
    int n_errors = 0;

    logic [ADDR_WIDTH-1:0] wr_addr[$];
    logic [31:0]           wr_data[$];

    uart_loader_if #(.ADDR_WIDTH(ADDR_WIDTH)) mem_if ();

    uart_loader #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .BASE_ADDR  (0),
        .MAX_WORDS  (2**ADDR_WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_update (rx_update),
        .rx_byte   (rx_byte),
        .mem       (mem_if),
        .cpu_rst_n (cpu_rst_n),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    // Log every accepted write
    always @(posedge clk) begin
        if (rst_n && mem_if.mem_wvalid && mem_if.mem_wready) begin
            wr_addr.push_back(mem_if.mem_waddr);
            wr_data.push_back(mem_if.mem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Toggle the strobe at a falling edge and return one cycle later,
    // after the byte event has been registered.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_byte   = b;
        rx_update = ~rx_update;
        @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int unsigned i = 0; i < 4; i++) begin
            logic [31:0] tmp;
            tmp = w >> (8 * i);
            send_byte(tmp[7:0]);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        wr_addr.delete();
        wr_data.delete();
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_wvalid"}, mem_if.mem_wvalid, 1'b0);
        check({tag, "_waddr"}, mem_if.mem_waddr, '0);
        check({tag, "_wdata"}, mem_if.mem_wdata, '0);
        check({tag, "_cpu_rst_n"}, cpu_rst_n, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_error"}, error, 1'b0);
    endtask

    initial begin
        mem_if.mem_wready = 1'b1;

        // Reset state
        do_reset();
        check_idle("rst");

        // N=1, payload 0x12345678, checksum 0x08
        send_byte(8'h01);
        check("t1_busy_hdr", busy, 1'b1);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_word(32'h1234_5678);
        check("t1_wvalid_rise", mem_if.mem_wvalid, 1'b1);
        check("t1_waddr", mem_if.mem_waddr, 12'h000);
        check("t1_wdata", mem_if.mem_wdata, 32'h1234_5678);
        check("t1_done_before_csum", done, 1'b0);
        send_byte(8'h08);
        check("t1_done", done, 1'b1);
        check("t1_cpu_rst_n", cpu_rst_n, 1'b1);
        check("t1_busy_end", busy, 1'b0);
        check("t1_nwrites", wr_addr.size(), 1);
        if (wr_addr.size() == 1) begin
            check("t1_log_addr", wr_addr[0], 12'h000);
            check("t1_log_data", wr_data[0], 32'h1234_5678);
        end
        send_byte(8'h55);
        check("t1_done_sticky", done, 1'b1);

        // N=0, checksum 0x00
        do_reset();
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        check("t2_busy_csum", busy, 1'b1);
        check("t2_done_early", done, 1'b0);
        send_byte(8'h00);
        check("t2_done", done, 1'b1);
        check("t2_nwrites", wr_addr.size(), 0);

        // N=2, wrong checksum (correct would be 0x08)
        do_reset();
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_word(32'h0403_0201);
        send_word(32'h0807_0605);
        check("t3_waddr_w1", mem_if.mem_waddr, 12'h001);
        send_byte(8'hFF);
        check("t3_error", error, 1'b1);
        check("t3_done", done, 1'b0);
        check("t3_cpu_rst_n", cpu_rst_n, 1'b0);
        check("t3_nwrites", wr_addr.size(), 2);
        if (wr_addr.size() == 2) begin
            check("t3_log_addr1", wr_addr[1], 12'h001);
            check("t3_log_data0", wr_data[0], 32'h0403_0201);
            check("t3_log_data1", wr_data[1], 32'h0807_0605);
        end

        // N = MAX_WORDS+1 = 0x1001
        do_reset();
        send_byte(8'h01); send_byte(8'h10); send_byte(8'h00);
        check("t4_error_early", error, 1'b0);
        send_byte(8'h00);
        check("t4_error", error, 1'b1);
        check("t4_busy", busy, 1'b0);
        send_word(32'h3322_1100);
        check("t4_error_sticky", error, 1'b1);
        check("t4_wvalid", mem_if.mem_wvalid, 1'b0);
        check("t4_nwrites", wr_addr.size(), 0);

        // Overrun: memory stalls through both words
        do_reset();
        mem_if.mem_wready = 1'b0;
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_word(32'hDEAD_BEEF);
        check("t5_wvalid_pending", mem_if.mem_wvalid, 1'b1);
        send_word(32'hCAFE_F00D);
        check("t5_error", error, 1'b1);
        check("t5_wvalid", mem_if.mem_wvalid, 1'b0);
        check("t5_nwrites", wr_addr.size(), 0);
        mem_if.mem_wready = 1'b1;

        // Priming cycle and mid-load reset
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        wr_addr.delete();
        wr_data.delete();
        rx_byte   = 8'h05;
        rx_update = ~rx_update;
        rst_n     = 1'b1;
        @(negedge clk);
        check("t6_prime_no_event", busy, 1'b0);
        rx_byte   = 8'h02;
        rx_update = ~rx_update;
        @(negedge clk);
        check("t6_after_prime_event", busy, 1'b1);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_word(32'h4433_2211);
        send_byte(8'h99);
        check("t6_wdata_before_rst", mem_if.mem_wdata, 32'h4433_2211);
        rst_n = 1'b0;
        #1;
        check_idle("t6_async_rst");
        do_reset();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_word(32'hDDCC_BBAA);
        send_byte(8'h00);
        check("t6_done", done, 1'b1);
        check("t6_nwrites", wr_addr.size(), 1);
        if (wr_addr.size() == 1) begin
            check("t6_log_addr", wr_addr[0], 12'h000);
            check("t6_log_data", wr_data[0], 32'hDDCC_BBAA);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
